// File: rtl/radar_video_capture.sv
// Radar sweep receiver: azimuth tracking from ARP/ACP and range-bin slicing into a tagged
// valid/ready stream. Define RVC_PEAK_DETECT_EN for per-bin peak detect instead of decimation.
module radar_video_capture #(
  parameter int unsigned VIDEO_W     = 12,
  parameter int unsigned AZ_W        = 12,
  parameter int unsigned ACP_PER_REV = 4096,
  parameter int unsigned RNG_W       = 10,
  parameter int unsigned RANGE_BINS  = 1024,
  parameter int unsigned DECIM       = 1,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arp,
  input  logic               acp,
  input  logic               trig,
  input  logic [VIDEO_W-1:0] video,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [VIDEO_W-1:0] out_data,
  output logic [RNG_W-1:0]   out_range,
  output logic [AZ_W-1:0]    out_az,
  output logic               out_sol,
  output logic               out_eol,
  output logic               az_locked,
  output logic               acp_err,
  output logic               ovf
);

  localparam int unsigned SUB_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = VIDEO_W + RNG_W + AZ_W;
  localparam logic [AZ_W-1:0]  AZ_LAST  = AZ_W'(ACP_PER_REV - 1);
  localparam logic [RNG_W-1:0] BIN_LAST = RNG_W'(RANGE_BINS - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(DECIM - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, CAPTURE} state_t;

  logic [2:0]         arp_sr, acp_sr, trig_sr;
  logic [VIDEO_W-1:0] video_d1, video_d2, video_d3;
  logic               arp_rise, acp_rise, trig_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arp_sr   <= '0;
      acp_sr   <= '0;
      trig_sr  <= '0;
      video_d1 <= '0;
      video_d2 <= '0;
      video_d3 <= '0;
    end else begin
      arp_sr   <= {arp_sr[1:0], arp};
      acp_sr   <= {acp_sr[1:0], acp};
      trig_sr  <= {trig_sr[1:0], trig};
      video_d1 <= video;
      video_d2 <= video_d1;
      video_d3 <= video_d2;
    end
  end

  assign arp_rise  = arp_sr[1]  & ~arp_sr[2];
  assign acp_rise  = acp_sr[1]  & ~acp_sr[2];
  assign trig_rise = trig_sr[1] & ~trig_sr[2];

  // wrapped marks an ACP wrap since the last ARP so a later az==AZ_LAST cannot fake a lock
  logic [AZ_W-1:0] az;
  logic            seen_arp, wrapped;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      az        <= '0;
      seen_arp  <= 1'b0;
      wrapped   <= 1'b0;
      az_locked <= 1'b0;
      acp_err   <= 1'b0;
    end else begin
      acp_err <= 1'b0;
      if (arp_rise) begin
        az       <= '0;
        seen_arp <= 1'b1;
        wrapped  <= 1'b0;
        if (seen_arp) begin
          if (!wrapped && az == AZ_LAST) begin
            az_locked <= 1'b1;
          end else begin
            az_locked <= 1'b0;
            acp_err   <= 1'b1;
          end
        end
      end else if (acp_rise) begin
        if (az == AZ_LAST) begin
          az        <= '0;
          wrapped   <= 1'b1;
          az_locked <= 1'b0;
          acp_err   <= 1'b1;
        end else begin
          az <= az + 1'b1;
        end
      end
    end
  end

  state_t             state, state_nx;
  logic [RNG_W-1:0]   bin, bin_nx;
  logic [SUB_W-1:0]   sub, sub_nx;
  logic [AZ_W-1:0]    line_az, line_az_nx;
  logic [VIDEO_W-1:0] acc, acc_nx, bin_val;
  logic               bin_done;

  always_comb begin
    state_nx   = state;
    bin_nx     = bin;
    sub_nx     = sub;
    line_az_nx = line_az;
    acc_nx     = acc;
    bin_done   = 1'b0;
`ifdef RVC_PEAK_DETECT_EN
    bin_val = (sub == '0 || video_d3 > acc) ? video_d3 : acc;
`else
    bin_val = (sub == '0) ? video_d3 : acc;
`endif
    case (state)
      IDLE: begin
        if (trig_rise) begin
          state_nx   = CAPTURE;
          bin_nx     = '0;
          sub_nx     = '0;
          line_az_nx = az;
        end
      end
      CAPTURE: begin
        acc_nx = bin_val;
        if (sub == SUB_LAST) begin
          bin_done = 1'b1;
          sub_nx   = '0;
          bin_nx   = bin + 1'b1;
          if (bin == BIN_LAST) state_nx = IDLE;
        end else begin
          sub_nx = sub + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  logic               push_vld;
  logic [VIDEO_W-1:0] push_data;
  logic [RNG_W-1:0]   push_rng;
  logic [AZ_W-1:0]    push_az;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bin       <= '0;
      sub       <= '0;
      line_az   <= '0;
      acc       <= '0;
      push_vld  <= 1'b0;
      push_data <= '0;
      push_rng  <= '0;
      push_az   <= '0;
    end else begin
      state     <= state_nx;
      bin       <= bin_nx;
      sub       <= sub_nx;
      line_az   <= line_az_nx;
      acc       <= acc_nx;
      push_vld  <= bin_done;
      push_data <= bin_val;
      push_rng  <= bin;
      push_az   <= line_az;
    end
  end

  // First-word-fall-through FIFO; a pop in the same cycle frees room for a push on full
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [ENT_W-1:0] rd_ent;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             pop, full, push_ok, drop;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (count == CNT_FULL);
  assign push_ok   = push_vld & (~full | pop);
  assign drop      = push_vld & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {push_data, push_rng, push_az};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)          ovf <= 1'b1;
      else if (arp_rise) ovf <= 1'b0;
    end
  end

  assign rd_ent    = mem[rd_ptr];
  assign out_data  = out_valid ? rd_ent[ENT_W-1 -: VIDEO_W] : '0;
  assign out_range = out_valid ? rd_ent[AZ_W +: RNG_W] : '0;
  assign out_az    = out_valid ? rd_ent[AZ_W-1:0] : '0;
  assign out_sol   = out_valid & (out_range == '0);
  assign out_eol   = out_valid & (out_range == BIN_LAST);

endmodule

// File: tb/tb_radar_video_capture.sv
// Scoreboard bench for radar_video_capture: a per-sample reference model fills an expected
// beat queue, and an independent monitor checks every presented beat against its head.
module tb_radar_video_capture;
  localparam int VIDEO_W     = 12;
  localparam int AZ_W        = 12;
  localparam int ACP_PER_REV = 4096;
  localparam int RNG_W       = 10;
  localparam int RANGE_BINS  = 1024;
  localparam int DECIM       = 4;
  localparam int FIFO_DEPTH  = 16;
  localparam int NSAMP       = RANGE_BINS * DECIM;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               arp = 1'b0, acp = 1'b0, trig = 1'b0, out_ready = 1'b0;
  logic [VIDEO_W-1:0] video = '0;
  logic               out_valid, out_sol, out_eol, az_locked, acp_err, ovf;
  logic [VIDEO_W-1:0] out_data;
  logic [RNG_W-1:0]   out_range;
  logic [AZ_W-1:0]    out_az;

  radar_video_capture #(
    .VIDEO_W(VIDEO_W), .AZ_W(AZ_W), .ACP_PER_REV(ACP_PER_REV), .RNG_W(RNG_W),
    .RANGE_BINS(RANGE_BINS), .DECIM(DECIM), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .arp(arp), .acp(acp), .trig(trig), .video(video),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_range(out_range), .out_az(out_az), .out_sol(out_sol), .out_eol(out_eol),
    .az_locked(az_locked), .acp_err(acp_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: works on pin samples; ACPs counted since last ARP, az = count mod rev
  typedef struct { int data; int rng; int az; } beat_t;
  beat_t expq[$];
  int    m_samp[$];
  int    m_n = 0, m_err = 0, m_t = 0, m_start = 0, m_busy = 0, m_laz = 0, outstanding = 0;
  int    m_v, m_b;
  bit    m_seen = 0, m_locked = 0, m_ovf = 0, m_line = 0;
  bit    p_arp = 0, p_acp = 0, p_trig = 0;

  always @(posedge clk) begin
    if (!rst) begin
      expq.delete();
      m_samp.delete();
      m_n = 0; m_t = 0; m_busy = 0; m_line = 0; outstanding = 0;
      m_seen = 0; m_locked = 0; m_ovf = 0;
      p_arp = 0; p_acp = 0; p_trig = 0;
    end else begin
      m_t++;
      if (trig && !p_trig && m_t > m_busy) begin
        m_line = 1; m_start = m_t; m_busy = m_t + NSAMP;
        m_laz = m_n % ACP_PER_REV;
        m_samp.delete();
      end
      if (m_line) begin
        m_samp.push_back(int'(video));
        if (m_samp.size() == DECIM) begin
          m_b = (m_t - m_start) / DECIM;
          m_v = m_samp[0];
`ifdef RVC_PEAK_DETECT_EN
          foreach (m_samp[i]) if (m_samp[i] > m_v) m_v = m_samp[i];
`endif
          if (outstanding >= FIFO_DEPTH) m_ovf = 1;
          else begin
            expq.push_back('{m_v, m_b, m_laz});
            outstanding++;
          end
          m_samp.delete();
          if (m_b == RANGE_BINS - 1) m_line = 0;
        end
      end
      if (arp && !p_arp) begin
        if (m_seen) begin
          if (m_n == ACP_PER_REV - 1) m_locked = 1;
          else begin m_locked = 0; m_err++; end
        end
        m_seen = 1; m_n = 0; m_ovf = 0;
      end else if (acp && !p_acp) begin
        m_n++;
        if (m_n % ACP_PER_REV == 0) begin m_err++; m_locked = 0; end
      end
      p_arp = arp; p_acp = acp; p_trig = trig;
    end
  end

  // Monitor: samples on the falling edge, away from DUT updates and stimulus changes
  int dut_err = 0;
  int t_vrise = -1;
  bit pv = 0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outputs", longint'({out_valid, out_data, out_range, out_az, out_sol,
                                     out_eol, az_locked, acp_err, ovf}), 0);
      pv = 0;
    end else begin
      if (acp_err) dut_err++;
      if (out_valid && !pv && t_vrise < 0) t_vrise = cyc;
      pv = out_valid;
      if (out_valid) begin
        if (expq.size() == 0) chk("unexpected_beat", longint'(out_valid), 0);
        else begin
          chk("out_data",  longint'(out_data),  expq[0].data);
          chk("out_range", longint'(out_range), expq[0].rng);
          chk("out_az",    longint'(out_az),    expq[0].az);
          chk("out_sol",   longint'(out_sol),   longint'(expq[0].rng == 0));
          chk("out_eol",   longint'(out_eol),   longint'(expq[0].rng == RANGE_BINS - 1));
          if (out_ready) begin
            void'(expq.pop_front());
            outstanding--;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_acp();
    acp = 1'b1; tick(); acp = 1'b0; tick();
  endtask

  task automatic pulse_arp();
    arp = 1'b1; tick(); arp = 1'b0; tick();
  endtask

  task automatic settle();
    repeat (6) tick();
  endtask

  task automatic check_status(input string name);
    chk({name, "_locked"}, longint'(az_locked), longint'(m_locked));
    chk({name, "_err_cycles"}, dut_err, m_err);
    chk({name, "_ovf"}, longint'(ovf), longint'(m_ovf));
  endtask

  task automatic drain(input string name, input int limit);
    int k = 0;
    while (expq.size() != 0 && k < limit) begin
      tick();
      k++;
    end
    chk({name, "_drained"}, expq.size(), 0);
  endtask

  int pat[4] = '{5, 9, 2, 7};
  int t_drive;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held with toggling inputs
    repeat (10) begin
      arp = 1'($urandom); acp = 1'($urandom); trig = 1'($urandom);
      video = VIDEO_W'($urandom); out_ready = 1'($urandom);
      tick();
    end
    arp = 0; acp = 0; trig = 0; video = '0; out_ready = 1;
    tick();
    rst = 1'b1;
    repeat (5) tick();
    check_status("post_reset");

    // full revolution, short revolution, wrap without ARP
    pulse_arp();
    repeat (ACP_PER_REV - 1) pulse_acp();
    pulse_arp();
    settle();
    check_status("rev_ok");
    repeat (ACP_PER_REV - 2) pulse_acp();
    pulse_arp();
    settle();
    check_status("rev_short");
    repeat (ACP_PER_REV) pulse_acp();
    settle();
    check_status("acp_wrap");

    // ramp line at az 37 with a second trig mid-line that must be ignored
    pulse_arp();
    repeat (37) pulse_acp();
    settle();
    out_ready = 1;
    t_vrise = -1;
    t_drive = cyc;
    trig = 1;
    for (int i = 0; i < NSAMP + 8; i++) begin
      video = VIDEO_W'(i);
      if (i == 3) trig = 0;
      if (i == NSAMP / 2) trig = 1;
      if (i == NSAMP / 2 + 2) trig = 0;
      tick();
    end
    drain("ramp", 300);
    chk("valid_latency", t_vrise - t_drive, 4 + DECIM);

    // same-cycle ARP and ACP, then one ACP: line tagged az 1, random video and ready
    pulse_arp();
    repeat (100) pulse_acp();
    arp = 1; acp = 1; tick();
    arp = 0; acp = 0; tick();
    pulse_acp();
    settle();
    check_status("arp_acp_same");
    trig = 1;
    for (int i = 0; i < NSAMP + 8; i++) begin
      video = VIDEO_W'($urandom);
      out_ready = ($urandom_range(3) != 0);
      if (i == 2) trig = 0;
      tick();
    end
    out_ready = 1;
    drain("random", 300);
    check_status("random_line");

    // 5,9,2,7 per bin: decimation keeps 5, peak detect keeps 9
    trig = 1;
    for (int i = 0; i < NSAMP + 8; i++) begin
      video = VIDEO_W'(pat[i % 4]);
      if (i == 2) trig = 0;
      tick();
    end
    drain("pattern", 300);

    // downstream stalled for a whole line: only FIFO_DEPTH beats survive
    out_ready = 0;
    trig = 1;
    for (int i = 0; i < NSAMP + 8; i++) begin
      video = VIDEO_W'($urandom);
      if (i == 2) trig = 0;
      tick();
    end
    settle();
    check_status("stalled_line");
    out_ready = 1;
    drain("stalled", 100);
    pulse_arp();
    settle();
    check_status("ovf_clear");

    // reset in the middle of a line flushes everything
    out_ready = 0;
    trig = 1;
    for (int i = 0; i < 200; i++) begin
      video = VIDEO_W'($urandom);
      if (i == 2) trig = 0;
      tick();
    end
    rst = 0;
    repeat (3) tick();
    rst = 1;
    out_ready = 1;
    repeat (30) tick();
    chk("flush_valid", longint'(out_valid), 0);
    check_status("mid_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
